// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice: the legal operand-width range.
package full_adder_pkg;

  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 64;

  // True when an operand width is within the supported range.
  function automatic bit width_legal(int unsigned width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: the leaf of the ripple-carry chain. Pure combinational.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic c_out
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  // Carry is generated by a&b, or propagated from cin when exactly one operand is set.
  assign c_out    = (a & b) | (cin & half_sum);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder, {c_out, sum} = a + b + cin, with an
// optional valid-qualified output register (REG_OUT=1: latency 1, else 0).
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] comb_sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .cin   (carry[i]),
      .sum   (comb_sum[i]),
      .c_out (carry[i+1])
    );
  end

  if (REG_OUT) begin : g_reg_out
    // Output register: synchronous reset clears everything; data loads only on
    // in_valid so unqualified (possibly X) inputs never reach sum/c_out.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
        sum       <= '0;
        c_out     <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum   <= comb_sum;
          c_out <= carry[WIDTH];
        end
      end
    end
  end else begin : g_comb_out
    // Reset only qualifies the valid flag; the data path stays purely combinational.
    assign sum       = comb_sum;
    assign c_out     = carry[WIDTH];
    assign out_valid = in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: three instances (1-bit registered,
// 8-bit registered, 4-bit combinational) driven by directed vectors, checked
// every cycle against an arithmetic model plus hand-computed literals.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;
  logic       v8, c8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov8;
  logic       v4, c4;
  logic [3:0] a4, b4, s4;
  logic       co4, ov4;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model state for the registered instances: {carry, sum} as one number.
  logic [1:0] m1   = '0;
  logic       m1_v = 1'b0;
  logic [8:0] m8   = '0;
  logic       m8_v = 1'b0;

  // Sum/carry truth tables for the 8 (a,b,cin) combinations, index = {a,b,cin}.
  logic [7:0] tt_sum = 8'h96;
  logic [7:0] tt_co  = 8'hE8;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .c_out(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .c_out(co8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .sum(s4), .c_out(co4), .out_valid(ov4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the registered behaviour: plain addition, load on valid, clear on reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m1 <= '0; m1_v <= 1'b0;
      m8 <= '0; m8_v <= 1'b0;
    end else begin
      m1_v <= v1;
      m8_v <= v8;
      if (v1) m1 <= 2'(a1) + 2'(b1) + 2'(c1);
      if (v8) m8 <= 9'(a8) + 9'(b8) + 9'(c8);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [4:0] e4;
      e4 = 5'(a4) + 5'(b4) + 5'(c4);
      check("u1.sum",       64'(s1),  64'(m1[0]));
      check("u1.c_out",     64'(co1), 64'(m1[1]));
      check("u1.out_valid", 64'(ov1), 64'(m1_v));
      check("u8.sum",       64'(s8),  64'(m8[7:0]));
      check("u8.c_out",     64'(co8), 64'(m8[8]));
      check("u8.out_valid", 64'(ov8), 64'(m8_v));
      check("u4.sum",       64'(s4),  64'(e4[3:0]));
      check("u4.c_out",     64'(co4), 64'(e4[4]));
      check("u4.out_valid", 64'(ov4), 64'(v4 & rst_n));
    end
  end

  // Advance to the next sampling point, then to the next input-drive point.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_drive();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    v4 = 1'b1; a4 = 4'h1;  b4 = 4'h1;  c4 = 1'b1;

    // Reset held two cycles with valid inputs present.
    @(posedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      to_sample();
      check("rst.sum",       64'(s1),  64'h0);
      check("rst.c_out",     64'(co1), 64'h0);
      check("rst.out_valid", 64'(ov1), 64'h0);
      check("rst.comb_ov",   64'(ov4), 64'h0);
    end

    // Release: first result one cycle later (1+1+1 = 2'b11).
    to_drive();
    rst_n = 1'b1;
    to_sample();
    check("rel.out_valid", 64'(ov1), 64'h1);
    check("rel.sum",       64'(s1),  64'h1);
    check("rel.c_out",     64'(co1), 64'h1);

    // Exhaustive 1-bit, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] vec;
      vec = 3'(i);
      to_drive();
      {a1, b1, c1} = vec;
      v1 = 1'b1;
      to_sample();
      check($sformatf("exh%0d.sum", i),   64'(s1),  64'(tt_sum[i]));
      check($sformatf("exh%0d.c_out", i), 64'(co1), 64'(tt_co[i]));
    end

    // Hold: load 1+0+1, then drop valid with random inputs.
    to_drive();
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; v1 = 1'b1;
    to_sample();
    check("hold.load_sum", 64'(s1),  64'h0);
    check("hold.load_co",  64'(co1), 64'h1);
    for (int i = 0; i < 3; i++) begin
      to_drive();
      v1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      to_sample();
      check("hold.sum",       64'(s1),  64'h0);
      check("hold.c_out",     64'(co1), 64'h1);
      check("hold.out_valid", 64'(ov1), 64'h0);
    end

    // Wide boundaries on the 8-bit instance.
    to_drive();
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
    to_sample();
    check("w8.ones", {55'h0, co8, s8}, 64'h1FF);
    to_drive();
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    to_sample();
    check("w8.msb", {55'h0, co8, s8}, 64'h100);
    to_drive();
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    to_sample();
    check("w8.zero", {55'h0, co8, s8}, 64'h000);

    // Combinational instance: same-cycle result, valid tracks in_valid and reset.
    to_drive();
    a4 = 4'h7; b4 = 4'h9; c4 = 1'b0; v4 = 1'b1;
    to_sample();
    check("c4.sum",   64'(s4),  64'h0);
    check("c4.c_out", 64'(co4), 64'h1);
    check("c4.ov_on", 64'(ov4), 64'h1);
    to_drive();
    v4 = 1'b0;
    to_sample();
    check("c4.ov_off", 64'(ov4), 64'h0);
    to_drive();
    v4 = 1'b1;
    to_sample();
    check("c4.ov_back", 64'(ov4), 64'h1);

    // Mid-stream reset on a continuous valid stream.
    for (int i = 0; i < 4; i++) begin
      to_drive();
      v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      to_sample();
    end
    to_drive();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    to_sample();
    check("mid.out_valid", 64'(ov1), 64'h0);
    check("mid.sum",       64'(s1),  64'h0);
    check("mid.c_out",     64'(co1), 64'h0);
    check("mid.comb_ov",   64'(ov4), 64'h0);
    to_drive();
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    to_sample();
    check("mid.resume_ov",  64'(ov1), 64'h1);
    check("mid.resume_sum", 64'(s1),  64'h1);
    check("mid.resume_co",  64'(co1), 64'h0);

    // A short random run checked only by the model.
    for (int i = 0; i < 20; i++) begin
      to_drive();
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      to_sample();
    end

    to_drive();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
